// File: rtl/instr_register_pkg.sv
// Shared types for the instruction register and its load sequencer.
`default_nettype none

package instr_register_pkg;

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  typedef logic signed [31:0] operand_t;
  typedef logic [4:0]         address_t;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t a;
    operand_t b;
  } instr_t;

endpackage

`default_nettype wire

// File: rtl/instr_fifo.sv
// Synchronous FIFO with power-of-two depth; full/empty flags and occupancy count.
`default_nettype none

module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 67,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is dropped even if a pop happens on the same edge.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_load_sequencer.sv
// Buffers incoming instructions and issues them as load_en strobes with an auto-incrementing write pointer.
`default_nettype none

module instr_load_sequencer
  import instr_register_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  opcode_t           in_opcode,
  input  operand_t          in_operand_a,
  input  operand_t          in_operand_b,
  input  logic              hold,
  input  logic              ptr_load,
  input  address_t          ptr_value,
  output logic              load_en,
  output address_t          write_pointer,
  output opcode_t           opcode,
  output operand_t          operand_a,
  output operand_t          operand_b,
  output logic [CNT_W-1:0]  issued_count,
  output logic              wrapped
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  instr_t          head, instr_q;
  logic            fifo_full, fifo_empty, push, pop;
  logic [CW-1:0]   fifo_count;
  seq_state_t      state_q, state_d;
  address_t        wp_q, wp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            wrapped_q, wrapped_d;

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(instr_t))
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_opcode, in_operand_a, in_operand_b}),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign in_ready = reset_n && (fifo_count != CW'(FIFO_DEPTH));
  assign push     = in_valid && !fifo_full && reset_n;
  assign pop      = !fifo_empty && !hold;

  // ISSUE marks the cycle in which a freshly popped instruction is on the outputs.
  always_comb begin
    state_d   = pop ? ISSUE : IDLE;
    wp_d      = wp_q;
    cnt_d     = cnt_q;
    wrapped_d = wrapped_q;
    if (ptr_load) begin
      wp_d = ptr_value;
    end else if (state_q == ISSUE) begin
      wp_d = wp_q + 5'd1;
      if (wp_q == '1) wrapped_d = 1'b1;
    end
    if (state_q == ISSUE && cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wp_q      <= '0;
      cnt_q     <= '0;
      wrapped_q <= 1'b0;
      instr_q   <= '{opc: ZERO, a: '0, b: '0};
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      cnt_q     <= cnt_d;
      wrapped_q <= wrapped_d;
      if (pop) instr_q <= head;
    end
  end

  assign load_en       = (state_q == ISSUE);
  assign write_pointer = wp_q;
  assign opcode        = instr_q.opc;
  assign operand_a     = instr_q.a;
  assign operand_b     = instr_q.b;
  assign issued_count  = cnt_q;
  assign wrapped       = wrapped_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_load_sequencer.sv
// Directed bench for instr_load_sequencer: vector table plus multi-cycle corner sequences.
`default_nettype none

module tb_instr_load_sequencer;
  import instr_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic in_valid, in_ready, hold, ptr_load, load_en, wrapped;
  opcode_t in_opcode, opcode;
  operand_t in_operand_a, in_operand_b, operand_a, operand_b;
  address_t ptr_value, write_pointer;
  logic [15:0] issued_count;

  logic s_in_valid, s_in_ready, s_load_en, s_wrapped;
  opcode_t s_opcode;
  operand_t s_operand_a, s_operand_b;
  address_t s_write_pointer;
  logic [1:0] s_issued_count;

  instr_load_sequencer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
    .hold(hold), .ptr_load(ptr_load), .ptr_value(ptr_value), .load_en(load_en),
    .write_pointer(write_pointer), .opcode(opcode), .operand_a(operand_a),
    .operand_b(operand_b), .issued_count(issued_count), .wrapped(wrapped)
  );

  instr_load_sequencer #(.FIFO_DEPTH(4), .CNT_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_opcode(ADD), .in_operand_a(in_operand_a), .in_operand_b(in_operand_b),
    .hold(1'b0), .ptr_load(1'b0), .ptr_value(5'd0), .load_en(s_load_en),
    .write_pointer(s_write_pointer), .opcode(s_opcode), .operand_a(s_operand_a),
    .operand_b(s_operand_b), .issued_count(s_issued_count), .wrapped(s_wrapped)
  );

  typedef struct {
    logic     v;
    opcode_t  opc;
    operand_t a;
    operand_t b;
    logic     ready;
    logic     le;
    address_t wp;
    opcode_t  eopc;
    operand_t ea;
    operand_t eb;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[7];
  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(logic v, opcode_t o, operand_t a, operand_t b, logic r,
                              logic le, address_t wp, opcode_t eo, operand_t ea,
                              operand_t eb, logic [15:0] cnt);
    vec_t t;
    t.v = v; t.opc = o; t.a = a; t.b = b; t.ready = r; t.le = le; t.wp = wp;
    t.eopc = eo; t.ea = ea; t.eb = eb; t.cnt = cnt;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  opcode_t bops[6];

  initial begin
    reset_n = 1'b0; in_valid = 0; in_opcode = ZERO; in_operand_a = 0; in_operand_b = 0;
    hold = 0; ptr_load = 0; ptr_value = 0; s_in_valid = 0;

    vecs[0] = mk(1, ADD,  5,  3,   1, 0, 0, ZERO, 0,  0,   0);
    vecs[1] = mk(0, ZERO, 0,  0,   1, 1, 0, ADD,  5,  3,   0);
    vecs[2] = mk(0, ZERO, 0,  0,   1, 0, 1, ADD,  5,  3,   1);
    vecs[3] = mk(1, SUB,  -7, 100, 1, 0, 1, ADD,  5,  3,   1);
    vecs[4] = mk(1, MULT, 2,  9,   1, 1, 1, SUB,  -7, 100, 1);
    vecs[5] = mk(0, ZERO, 0,  0,   1, 1, 2, MULT, 2,  9,   2);
    vecs[6] = mk(0, ZERO, 0,  0,   1, 0, 3, MULT, 2,  9,   3);
    bops = '{PASSA, PASSB, ADD, SUB, MULT, DIV};

    #2;
    chk("rst_in_ready", in_ready, 0);
    repeat (2) step();
    chk("rst_load_en", load_en, 0);
    chk("rst_wp", write_pointer, 0);
    chk("rst_opcode", opcode, ZERO);
    chk("rst_count", issued_count, 0);
    chk("rst_wrapped", wrapped, 0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 7; i++) begin
      in_valid = vecs[i].v; in_opcode = vecs[i].opc;
      in_operand_a = vecs[i].a; in_operand_b = vecs[i].b;
      chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].ready);
      step();
      chk($sformatf("v%0d_load_en", i), load_en, vecs[i].le);
      chk($sformatf("v%0d_wp", i), write_pointer, vecs[i].wp);
      chk($sformatf("v%0d_opcode", i), opcode, vecs[i].eopc);
      chk($sformatf("v%0d_a", i), operand_a, vecs[i].ea);
      chk($sformatf("v%0d_b", i), operand_b, vecs[i].eb);
      chk($sformatf("v%0d_count", i), issued_count, vecs[i].cnt);
    end
    in_valid = 0;

    // Burst into a held FIFO: only 4 entries fit, then 4 back-to-back issues at 0..3.
    ptr_load = 1; ptr_value = 0; step(); ptr_load = 0;
    hold = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1; in_opcode = bops[k]; in_operand_a = k * 10; in_operand_b = k + 100;
      chk($sformatf("burst_in_ready%0d", k), in_ready, (k < 4) ? 1'b1 : 1'b0);
      step();
    end
    in_valid = 0;
    step();
    chk("burst_held_load_en", load_en, 0);
    hold = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("burst_le%0d", k), load_en, 1);
      chk($sformatf("burst_wp%0d", k), write_pointer, k);
      chk($sformatf("burst_opc%0d", k), opcode, bops[k]);
      chk($sformatf("burst_a%0d", k), operand_a, k * 10);
    end
    step();
    chk("burst_end_le", load_en, 0);
    chk("burst_end_wp", write_pointer, 4);
    chk("burst_end_ready", in_ready, 1);

    // ptr_load during an issue: that write stays at 4, the next goes to 10.
    in_valid = 1; in_opcode = DIV; in_operand_a = 1; in_operand_b = 2; step();
    in_opcode = MOD; in_operand_a = 3; in_operand_b = 4; step();
    chk("prio_le0", load_en, 1);
    chk("prio_wp0", write_pointer, 4);
    chk("prio_opc0", opcode, DIV);
    in_valid = 0; ptr_load = 1; ptr_value = 10; step(); ptr_load = 0;
    chk("prio_le1", load_en, 1);
    chk("prio_wp1", write_pointer, 10);
    chk("prio_opc1", opcode, MOD);
    step();
    chk("prio_le2", load_en, 0);
    chk("prio_wp2", write_pointer, 11);

    // Pointer wrap 30,31,0.
    ptr_load = 1; ptr_value = 30; step(); ptr_load = 0;
    chk("wrap_pre_wrapped", wrapped, 0);
    in_valid = 1; in_opcode = ADD; in_operand_a = 0; step();
    in_opcode = SUB; in_operand_a = 1; step();
    chk("wrap_wp30", write_pointer, 30);
    chk("wrap_le30", load_en, 1);
    in_opcode = MULT; in_operand_a = 2; step();
    in_valid = 0;
    chk("wrap_wp31", write_pointer, 31);
    chk("wrap_before", wrapped, 0);
    step();
    chk("wrap_wp0", write_pointer, 0);
    chk("wrap_opc0", opcode, MULT);
    chk("wrap_after", wrapped, 1);
    step();
    chk("wrap_idle_le", load_en, 0);
    chk("wrap_idle_wp", write_pointer, 1);
    chk("wrap_sticky", wrapped, 1);
    chk("total_count", issued_count, 12);

    // Reset in the middle of a burst with entries still queued.
    hold = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1; in_opcode = bops[k]; in_operand_a = k; step();
    end
    in_valid = 0; hold = 0; step();
    chk("mid_le", load_en, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_le", load_en, 0);
    chk("mid_rst_wp", write_pointer, 0);
    chk("mid_rst_opc", opcode, ZERO);
    chk("mid_rst_count", issued_count, 0);
    chk("mid_rst_wrapped", wrapped, 0);
    chk("mid_rst_ready", in_ready, 0);
    step();
    chk("mid_rst_le2", load_en, 0);
    @(negedge clk) reset_n = 1'b1;
    step();
    chk("mid_post_le", load_en, 0);
    chk("mid_post_ready", in_ready, 1);
    step();
    chk("mid_flushed_le", load_en, 0);
    chk("mid_flushed_wp", write_pointer, 0);

    // Saturating counter on the 2-bit instance.
    for (int k = 0; k < 5; k++) begin
      s_in_valid = 1; step();
      if (k == 3) chk("sat_count_mid", s_issued_count, 2);
    end
    s_in_valid = 0;
    repeat (3) step();
    chk("sat_count", s_issued_count, 3);
    chk("sat_wp", s_write_pointer, 5);
    s_in_valid = 1; step(); step(); s_in_valid = 0;
    repeat (3) step();
    chk("sat_hold", s_issued_count, 3);
    chk("sat_wp2", s_write_pointer, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
